// File: rtl/clk_div_gen.sv
// Game-speed clock divider: square wave plus rise tick, power-of-two rates, run/pause/single-step.
// Optional tick counter output enabled by defining CLK_DIV_GEN_TICK_CNT_EN.
module clk_div_gen #(
    parameter int CNT_W     = 32,
    parameter int BASE_HALF = 12500,
    parameter int RATE_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              step,
    input  logic [RATE_W-1:0] rate_sel,
`ifdef CLK_DIV_GEN_TICK_CNT_EN
    output logic [15:0]       tick_cnt,
`endif
    output logic              clk_game,
    output logic              tick,
    output logic [RATE_W-1:0] rate_cur,
    output logic              running
);

    localparam int MAX_SH  = (1 << RATE_W) - 1;
    localparam int SH_ROOM = (CNT_W > MAX_SH) ? (CNT_W - MAX_SH) : 0;
    localparam logic [CNT_W-1:0] BASE_W = CNT_W'(BASE_HALF);

    // The slowest half-period must still fit the counter.
    generate
        if (BASE_HALF < 1 || SH_ROOM == 0 || (longint'(BASE_HALF) >> SH_ROOM) != 0) begin : g_bad_cfg
            $error("clk_div_gen: BASE_HALF out of range for CNT_W/RATE_W");
        end
    endgenerate

    typedef enum logic [1:0] {PAUSED, RUNNING, STEPPING} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clk_game_q, clk_game_d;
    logic              tick_q, tick_d;
    logic [RATE_W-1:0] rate_cur_q, rate_cur_d;
    logic              running_q, running_d;
    logic              step_s_q, step_s_d;
    logic [CNT_W-1:0]  lim;
    logic              active;
    logic              boundary;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk_game_d = clk_game_q;
        tick_d     = 1'b0;
        rate_cur_d = rate_cur_q;
        step_s_d   = step_s_q;

        lim      = BASE_W << rate_cur_q;
        // A RUNNING cycle that sees en low already holds the counter.
        active   = (state_q == RUNNING && en) || (state_q == STEPPING);
        boundary = active && (cnt_q == lim - CNT_W'(1));

        if (boundary) begin
            cnt_d      = '0;
            clk_game_d = ~clk_game_q;
            tick_d     = ~clk_game_q;
            rate_cur_d = rate_sel;
        end else if (active) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            PAUSED: begin
                if (en) begin
                    state_d = RUNNING;
                end else if (step) begin
                    state_d  = STEPPING;
                    step_s_d = clk_game_q;
                end
            end
            RUNNING: begin
                if (!en) state_d = PAUSED;
            end
            STEPPING: begin
                // Second toggle brings the level back to where the step began.
                if (en) state_d = RUNNING;
                else if (boundary && (~clk_game_q == step_s_q)) state_d = PAUSED;
            end
            default: state_d = PAUSED;
        endcase

        running_d = (state_d != PAUSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PAUSED;
            cnt_q      <= '0;
            clk_game_q <= 1'b0;
            tick_q     <= 1'b0;
            rate_cur_q <= '0;
            running_q  <= 1'b0;
            step_s_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_game_q <= clk_game_d;
            tick_q     <= tick_d;
            rate_cur_q <= rate_cur_d;
            running_q  <= running_d;
            step_s_q   <= step_s_d;
        end
    end

    assign clk_game = clk_game_q;
    assign tick     = tick_q;
    assign rate_cur = rate_cur_q;
    assign running  = running_q;

`ifdef CLK_DIV_GEN_TICK_CNT_EN
    logic [15:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q + {15'd0, tick_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick_cnt_d;
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: vector table, directed corner sequences, random run vs model.
module tb_clk_div_gen;

    localparam int CNT_W  = 16;
    localparam int BASE   = 4;
    localparam int RATE_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              step = 1'b0;
    logic [RATE_W-1:0] rate_sel = '0;
    logic              clk_game, tick, running;
    logic [RATE_W-1:0] rate_cur;
`ifdef CLK_DIV_GEN_TICK_CNT_EN
    logic [15:0]       tick_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    clk_div_gen #(.CNT_W(CNT_W), .BASE_HALF(BASE), .RATE_W(RATE_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .step(step), .rate_sel(rate_sel),
`ifdef CLK_DIV_GEN_TICK_CNT_EN
        .tick_cnt(tick_cnt),
`endif
        .clk_game(clk_game), .tick(tick), .rate_cur(rate_cur), .running(running)
    );

    always #5 clk = ~clk;

    // Reference: position within the current half, level, and toggles left in a step.
    typedef struct {
        int mode;   // 0 paused, 1 running, 2 stepping
        int pos;
        bit lvl;
        bit tk;
        int rate;
        int left;
        int tcnt;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mstep(mdl_t m, bit e, bit s, int rs);
        mdl_t n = m;
        bit act;
        n.tk = 1'b0;
        n.tcnt = (m.tcnt + (m.tk ? 1 : 0)) % 65536;
        act = (m.mode == 1 && e) || m.mode == 2;
        if (act) begin
            if (m.pos + 1 == (BASE << m.rate)) begin
                n.pos  = 0;
                n.lvl  = !m.lvl;
                n.tk   = n.lvl;
                n.rate = rs;
                n.left = m.left - 1;
            end else begin
                n.pos = m.pos + 1;
            end
        end
        case (m.mode)
            0: if (e) n.mode = 1; else if (s) begin n.mode = 2; n.left = 2; end
            1: if (!e) n.mode = 0;
            default: if (e) n.mode = 1; else if (n.left == 0) n.mode = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '{default: 0};
        else        mdl <= mstep(mdl, en, step, int'(rate_sel));
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; step = 1'b0; rate_sel = '0;
        #1;
        chk("rst_state", {12'd0, clk_game, tick, running, 1'b0}, 16'd0);
        chk("rst_rate", 16'(rate_cur), 16'd0);
        repeat (2) edge1();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit              en;
        bit              step;
        logic [RATE_W-1:0] rs;
        bit              cg;
        bit              tk;
        bit              rn;
        logic [RATE_W-1:0] rc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int ticks, high;

        // Free run at rate 0: edge 1 only starts, first rise at edge 5, period 8.
        for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0};
        for (int i = 4; i < 8; i++) tbl[i].cg = 1'b1;
        tbl[4].tk = 1'b1;

        do_reset();
        foreach (tbl[i]) begin
            en = tbl[i].en; step = tbl[i].step; rate_sel = tbl[i].rs;
            edge1();
            chk($sformatf("tbl[%0d]", i), {12'd0, clk_game, tick, running, 1'b0},
                {12'd0, tbl[i].cg, tbl[i].tk, tbl[i].rn, 1'b0});
            chk($sformatf("tbl_rate[%0d]", i), 16'(rate_cur), 16'(tbl[i].rc));
        end

        // Rate change requested at cnt=1 of a half: that half still lasts 4.
        do_reset();
        en = 1'b1;
        repeat (6) edge1();
        rate_sel = 2'd2;
        repeat (2) edge1();
        chk("rc_hold_lvl", 16'(clk_game), 16'd1);
        chk("rc_hold_rate", 16'(rate_cur), 16'd0);
        edge1();
        chk("rc_bound_lvl", 16'(clk_game), 16'd0);
        chk("rc_bound_rate", 16'(rate_cur), 16'd2);
        repeat (15) edge1();
        chk("rc_long_half", 16'(clk_game), 16'd0);
        edge1();
        chk("rc_rise", {14'd0, clk_game, tick}, 16'd3);
        repeat (15) edge1();
        chk("rc_high16", 16'(clk_game), 16'd1);
        edge1();
        chk("rc_fall", 16'(clk_game), 16'd0);

        // Pause at cnt=2 keeps the partial half.
        do_reset();
        en = 1'b1;
        repeat (7) edge1();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge1();
            chk("pause_hold", {14'd0, clk_game, running}, 16'd2);
        end
        en = 1'b1;
        edge1();
        chk("resume_state", {14'd0, clk_game, running}, 16'd3);
        edge1();
        chk("resume_cnt3", 16'(clk_game), 16'd1);
        edge1();
        chk("resume_toggle", 16'(clk_game), 16'd0);

        // Single step at rate 1; a second step mid-period is ignored.
        do_reset();
        rate_sel = 2'd1; en = 1'b1;
        repeat (13) edge1();
        chk("step_prep", {12'd0, clk_game, 1'b0, rate_cur}, 16'd1);
        en = 1'b0;
        edge1();
        chk("step_paused", 16'(running), 16'd0);
        step = 1'b1;
        edge1();
        step = 1'b0;
        ticks = 0; high = 0;
        for (int k = 2; k <= 30; k++) begin
            step = (k == 4);
            edge1();
            ticks += tick;
            high  += clk_game;
            if (k == 16) chk("step_run16", {14'd0, clk_game, running}, 16'd3);
            if (k == 17) chk("step_end17", {14'd0, clk_game, running}, 16'd0);
        end
        step = 1'b0;
        chk("step_ticks", 16'(ticks), 16'd1);
        chk("step_high", 16'(high), 16'd8);
        chk("step_final", {14'd0, clk_game, running}, 16'd0);

        // Asynchronous reset in the middle of a rate-3 half.
        do_reset();
        rate_sel = 2'd3; en = 1'b1;
        repeat (15) edge1();
        chk("ar_pre", {12'd0, clk_game, running, rate_cur}, 16'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_now", {12'd0, clk_game, tick, running, 1'b0}, 16'd0);
        chk("ar_rate", 16'(rate_cur), 16'd0);
        edge1();
        rst_n = 1'b1; rate_sel = 2'd0;
        repeat (4) edge1();
        chk("ar_edge4", 16'(clk_game), 16'd0);
        edge1();
        chk("ar_edge5", {14'd0, clk_game, tick}, 16'd3);

        // Random traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(15) == 0) en = ~en;
            step = ($urandom_range(9) == 0);
            if ($urandom_range(39) == 0) rate_sel = RATE_W'($urandom_range(3));
            rst_n = ($urandom_range(599) != 0);
            edge1();
            chk("rnd_out", {12'd0, clk_game, tick, running, 1'b0},
                {12'd0, mdl.lvl, mdl.tk, mdl.mode != 0, 1'b0});
            chk("rnd_rate", 16'(rate_cur), 16'(mdl.rate));
`ifdef CLK_DIV_GEN_TICK_CNT_EN
            chk("rnd_tcnt", tick_cnt, 16'(mdl.tcnt));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
